// File: rtl/pipeline_elastic_fifo.sv
// Elastic valid/ready buffer of DEPTH words with occupancy count, almost-full flag
// and synchronous flush; the upstream ready depends only on registered state and iFlush.
module pipeline_elastic_fifo #(
   parameter  int WD       = 8,
   parameter  int DEPTH    = 4,
   parameter  int AF_LEVEL = 3,
   localparam int CW       = $clog2(DEPTH + 1)
) (
   input  logic          iCLK,
   input  logic          iRST,
   input  logic          iFlush,
   input  logic          iValid_AS,
   output logic          oReady_AS,
   input  logic [WD-1:0] iData_AS,
   output logic          oValid_BS,
   input  logic          iReady_BS,
   output logic [WD-1:0] oData_BS,
   output logic [CW-1:0] oCount,
   output logic          oAlmostFull
);
   localparam int            PW       = $clog2(DEPTH);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

   logic [WD-1:0] r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_push;
   logic          w_pop;

   // Pointers wrap explicitly so DEPTH need not be a power of two.
   function automatic logic [PW-1:0] f_next_ptr(input logic [PW-1:0] ptr);
      return (ptr == LAST_PTR) ? {PW{1'b0}} : ptr + PW'(1);
   endfunction

   assign oReady_AS   = (r_count != FULL_CNT) & ~iFlush;
   assign oValid_BS   = (r_count != {CW{1'b0}});
   assign oData_BS    = r_mem[r_rd_ptr];
   assign oCount      = r_count;
   assign oAlmostFull = (r_count >= AF_CNT);
   assign w_push      = iValid_AS & oReady_AS;
   assign w_pop       = oValid_BS & iReady_BS;

   // Storage: cleared on reset only; a flush leaves contents behind oValid_BS=0.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= {WD{1'b0}};
         end
      end else if (w_push) begin
         r_mem[r_wr_ptr] <= iData_AS;
      end else begin
         r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
      end
   end

   // Pointer and occupancy state; reset beats flush beats normal traffic.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         r_wr_ptr <= {PW{1'b0}};
         r_rd_ptr <= {PW{1'b0}};
         r_count  <= {CW{1'b0}};
      end else if (iFlush) begin
         r_wr_ptr <= {PW{1'b0}};
         r_rd_ptr <= {PW{1'b0}};
         r_count  <= {CW{1'b0}};
      end else begin
         if (w_push) begin
            r_wr_ptr <= f_next_ptr(r_wr_ptr);
         end else begin
            r_wr_ptr <= r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= f_next_ptr(r_rd_ptr);
         end else begin
            r_rd_ptr <= r_rd_ptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

// File: tb/tb_pipeline_elastic_fifo.sv
// Self-checking bench: directed vector table and streaming on DEPTH=4, random traffic
// with a mid-burst reset on DEPTH=3, both shadowed by queue-based scoreboards.
module tb_pipeline_elastic_fifo;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   bit mon_en = 1'b0;

   // DEPTH=4, AF_LEVEL=3 instance
   logic       rst4 = 1'b1, flush4 = 1'b0, val4 = 1'b0, rdy4 = 1'b0;
   logic [7:0] din4 = 8'h00;
   logic       o_ready4, o_valid4, o_af4;
   logic [7:0] o_data4;
   logic [2:0] o_count4;

   // DEPTH=3, AF_LEVEL=2 instance
   logic       rst3 = 1'b1, flush3 = 1'b0, val3 = 1'b0, rdy3 = 1'b0;
   logic [7:0] din3 = 8'h00;
   logic       o_ready3, o_valid3, o_af3;
   logic [7:0] o_data3;
   logic [1:0] o_count3;

   pipeline_elastic_fifo #(.WD(8), .DEPTH(4), .AF_LEVEL(3)) u_dut4 (
      .iCLK(clk), .iRST(rst4), .iFlush(flush4), .iValid_AS(val4), .oReady_AS(o_ready4),
      .iData_AS(din4), .oValid_BS(o_valid4), .iReady_BS(rdy4), .oData_BS(o_data4),
      .oCount(o_count4), .oAlmostFull(o_af4));

   pipeline_elastic_fifo #(.WD(8), .DEPTH(3), .AF_LEVEL(2)) u_dut3 (
      .iCLK(clk), .iRST(rst3), .iFlush(flush3), .iValid_AS(val3), .oReady_AS(o_ready3),
      .iData_AS(din3), .oValid_BS(o_valid3), .iReady_BS(rdy3), .oData_BS(o_data3),
      .oCount(o_count3), .oAlmostFull(o_af3));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard models: expected data queue per instance, occupancy = queue size.
   logic [7:0] q4[$];
   logic [7:0] q3[$];
   int         m4_cnt = 0, m3_cnt = 0, pops4 = 0, pops3 = 0;
   bit         stall4 = 1'b0, stall3 = 1'b0;
   logic [7:0] prev4 = 8'h00, prev3 = 8'h00;

   always @(negedge clk) begin
      if (mon_en) begin
         chk("sb4_valid", {31'd0, o_valid4}, {31'd0, m4_cnt != 0});
         chk("sb4_ready", {31'd0, o_ready4}, {31'd0, (m4_cnt != 4) && !flush4});
         chk("sb4_count", {29'd0, o_count4}, m4_cnt);
         chk("sb4_af", {31'd0, o_af4}, {31'd0, m4_cnt >= 3});
         if (stall4) chk("sb4_stable", {24'd0, o_data4}, {24'd0, prev4});
         if (m4_cnt != 0 && rdy4 && q4.size() > 0) chk("sb4_data", {24'd0, o_data4}, {24'd0, q4[0]});
         stall4 = (m4_cnt != 0) && !rdy4 && !flush4 && !rst4;
         prev4  = o_data4;
         if (rst4) begin
            q4.delete();
         end else begin
            if (m4_cnt != 0 && rdy4 && q4.size() > 0) begin
               void'(q4.pop_front());
               pops4++;
            end
            if (m4_cnt != 4 && !flush4 && val4) q4.push_back(din4);
            if (flush4) q4.delete();
         end
         m4_cnt = q4.size();
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         chk("sb3_valid", {31'd0, o_valid3}, {31'd0, m3_cnt != 0});
         chk("sb3_ready", {31'd0, o_ready3}, {31'd0, (m3_cnt != 3) && !flush3});
         chk("sb3_count", {30'd0, o_count3}, m3_cnt);
         chk("sb3_af", {31'd0, o_af3}, {31'd0, m3_cnt >= 2});
         if (stall3) chk("sb3_stable", {24'd0, o_data3}, {24'd0, prev3});
         if (m3_cnt != 0 && rdy3 && q3.size() > 0) chk("sb3_data", {24'd0, o_data3}, {24'd0, q3[0]});
         stall3 = (m3_cnt != 0) && !rdy3 && !flush3 && !rst3;
         prev3  = o_data3;
         if (rst3) begin
            q3.delete();
         end else begin
            if (m3_cnt != 0 && rdy3 && q3.size() > 0) begin
               void'(q3.pop_front());
               pops3++;
            end
            if (m3_cnt != 3 && !flush3 && val3) q3.push_back(din3);
            if (flush3) q3.delete();
         end
         m3_cnt = q3.size();
      end
   end

   typedef struct {
      logic       flush, valid, ready;
      logic [7:0] data;
      logic       ev, er;
      logic [2:0] ec;
      logic       eaf;
      logic [7:0] ed;
   } vec_t;
   vec_t vecs[$];

   task automatic add(input logic f, input logic v, input logic r, input logic [7:0] d,
                      input logic ev, input logic er, input logic [2:0] ec, input logic eaf,
                      input logic [7:0] ed);
      vec_t t;
      t = '{f, v, r, d, ev, er, ec, eaf, ed};
      vecs.push_back(t);
   endtask

   initial begin
      int base;
      // flush valid ready data | exp: valid ready count af data (state before the edge)
      add(1'b0, 1'b0, 1'b0, 8'h00,  1'b0, 1'b1, 3'd0, 1'b0, 8'h00); // idle after reset
      add(1'b0, 1'b1, 1'b0, 8'h11,  1'b0, 1'b1, 3'd0, 1'b0, 8'h00);
      add(1'b0, 1'b1, 1'b0, 8'h12,  1'b1, 1'b1, 3'd1, 1'b0, 8'h11);
      add(1'b0, 1'b1, 1'b0, 8'h13,  1'b1, 1'b1, 3'd2, 1'b0, 8'h11);
      add(1'b0, 1'b1, 1'b0, 8'h14,  1'b1, 1'b1, 3'd3, 1'b1, 8'h11);
      add(1'b0, 1'b1, 1'b0, 8'h99,  1'b1, 1'b0, 3'd4, 1'b1, 8'h11); // full: push refused
      add(1'b0, 1'b1, 1'b1, 8'h15,  1'b1, 1'b0, 3'd4, 1'b1, 8'h11); // pop only
      add(1'b0, 1'b1, 1'b1, 8'h15,  1'b1, 1'b1, 3'd3, 1'b1, 8'h12); // push+pop
      add(1'b0, 1'b0, 1'b1, 8'h00,  1'b1, 1'b1, 3'd3, 1'b1, 8'h13);
      add(1'b0, 1'b1, 1'b0, 8'h16,  1'b1, 1'b1, 3'd2, 1'b0, 8'h14);
      add(1'b1, 1'b1, 1'b1, 8'h77,  1'b1, 1'b0, 3'd3, 1'b1, 8'h14); // flush, head consumed
      add(1'b0, 1'b0, 1'b0, 8'h00,  1'b0, 1'b1, 3'd0, 1'b0, 8'h15); // stale mem[0]
      add(1'b0, 1'b1, 1'b0, 8'h21,  1'b0, 1'b1, 3'd0, 1'b0, 8'h15);
      add(1'b0, 1'b0, 1'b0, 8'h00,  1'b1, 1'b1, 3'd1, 1'b0, 8'h21);
      add(1'b0, 1'b0, 1'b1, 8'h00,  1'b1, 1'b1, 3'd1, 1'b0, 8'h21);
      add(1'b0, 1'b0, 1'b0, 8'h00,  1'b0, 1'b1, 3'd0, 1'b0, 8'h16); // stale mem[1]

      repeat (2) @(posedge clk);
      #1 mon_en = 1'b1;
      @(posedge clk);
      #1 rst4 = 1'b0; rst3 = 1'b0;

      foreach (vecs[i]) begin
         if (i != 0) begin
            @(posedge clk);
            #1;
         end
         flush4 = vecs[i].flush; val4 = vecs[i].valid; rdy4 = vecs[i].ready; din4 = vecs[i].data;
         @(negedge clk);
         chk("vec_valid", {31'd0, o_valid4}, {31'd0, vecs[i].ev});
         chk("vec_ready", {31'd0, o_ready4}, {31'd0, vecs[i].er});
         chk("vec_count", {29'd0, o_count4}, {29'd0, vecs[i].ec});
         chk("vec_af", {31'd0, o_af4}, {31'd0, vecs[i].eaf});
         chk("vec_data", {24'd0, o_data4}, {24'd0, vecs[i].ed});
      end

      // Streaming: one word per cycle, occupancy pinned at 1.
      base = pops4;
      for (int i = 0; i < 64; i++) begin
         @(posedge clk);
         #1 flush4 = 1'b0; val4 = 1'b1; rdy4 = 1'b1; din4 = 8'(i);
         @(negedge clk);
         if (i > 0) chk("stream_count", {29'd0, o_count4}, 32'd1);
      end
      @(posedge clk);
      #1 val4 = 1'b0;
      repeat (2) @(posedge clk);
      #1 rdy4 = 1'b0;
      chk("stream_pops", pops4 - base, 32'd64);

      // Random traffic on DEPTH=3 with a reset in the middle of the burst.
      for (int i = 0; i < 400; i++) begin
         @(posedge clk);
         #1 rst3 = (i == 200);
         val3 = 1'($urandom_range(0, 1)); rdy3 = 1'($urandom_range(0, 1));
         din3 = 8'($urandom_range(0, 255));
         flush3 = ($urandom_range(0, 49) == 0);
         if (i == 201) begin
            @(negedge clk);
            chk("rst3_count", {30'd0, o_count3}, 32'd0);
            chk("rst3_valid", {31'd0, o_valid3}, 32'd0);
         end
      end
      @(posedge clk);
      #1 rst3 = 1'b0; flush3 = 1'b0; val3 = 1'b0; rdy3 = 1'b1;
      for (int i = 0; i < 10 && m3_cnt != 0; i++) @(posedge clk);
      @(negedge clk);
      chk("drain3_valid", {31'd0, o_valid3}, 32'd0);
      chk("drain3_count", {30'd0, o_count3}, 32'd0);
      chk("random_pops_seen", {31'd0, pops3 > 20}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
